// File: rtl/coin_change_dispenser_if.sv
// ============================================================================
//  Module      : coin_change_dispenser_if
//  Description : Refund-request and coin-ejection handshake bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface coin_change_dispenser_if #(
    parameter int AMT_W = 4
) ();
    logic             req_valid;
    logic [AMT_W-1:0] req_amt;
    logic             req_ready;
    logic [1:0]       coin;
    logic             coin_valid;
    logic             coin_ack;

    modport master (
        output req_valid, req_amt, coin_ack,
        input  req_ready, coin, coin_valid
    );

    modport slave (
        input  req_valid, req_amt, coin_ack,
        output req_ready, coin, coin_valid
    );
endinterface

`default_nettype wire

// File: rtl/coin_change_dispenser.sv
// ============================================================================
//  Module      : coin_change_dispenser
//  Description : Greedy one-coin-at-a-time change payout with ack timeout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module coin_change_dispenser #(
    parameter int AMT_W    = 4,
    parameter int COIN_GAP = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    coin_change_dispenser_if.slave bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [AMT_W-1:0]       remaining
);

    localparam int TMR_W    = $clog2(TIMEOUT + 1);
    localparam int GAP_W    = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;
    localparam int GAP_LAST = (COIN_GAP > 0) ? COIN_GAP - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_DRIVE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   rem_q,   rem_d;
    logic [1:0]         sel_q,   sel_d;
    logic [TMR_W-1:0]   tmr_q,   tmr_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;
    logic               err_q,   err_d;

    logic [AMT_W-1:0]   sel_val;
    logic [AMT_W-1:0]   rem_after;
    logic [TMR_W-1:0]   tmr_inc;

    always_comb begin
        case (sel_q)
            2'b11:   sel_val = AMT_W'(5);
            2'b10:   sel_val = AMT_W'(2);
            default: sel_val = AMT_W'(1);
        endcase
        // Greedy selection guarantees sel_val <= rem_q, so no underflow here.
        rem_after = rem_q - sel_val;
        tmr_inc   = tmr_q + TMR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        tmr_d   = tmr_q;
        gap_d   = gap_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    rem_d   = bus.req_amt;
                    err_d   = 1'b0;
                    state_d = (bus.req_amt == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem_q >= AMT_W'(5))      sel_d = 2'b11;
                else if (rem_q >= AMT_W'(2)) sel_d = 2'b10;
                else                         sel_d = 2'b01;
                tmr_d   = '0;
                state_d = S_DRIVE;
            end
            S_DRIVE: begin
                // An ack on the timeout edge takes priority over the abort.
                if (bus.coin_ack) begin
                    rem_d = rem_after;
                    if (rem_after == '0) begin
                        state_d = S_DONE;
                    end else if (COIN_GAP == 0) begin
                        state_d = S_SELECT;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end else if (tmr_inc == TMR_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) state_d = S_SELECT;
                else                           gap_d   = gap_q + GAP_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            sel_q   <= 2'b01;
            tmr_q   <= '0;
            gap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            tmr_q   <= tmr_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.coin_valid = (state_q == S_DRIVE);
    assign bus.coin       = (state_q == S_DRIVE) ? sel_q : 2'b00;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign err            = err_q;
    assign remaining      = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_coin_change_dispenser.sv
// ============================================================================
//  Module      : tb_coin_change_dispenser
//  Description : Randomized scoreboard bench for coin_change_dispenser.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_coin_change_dispenser;

    localparam int AMT_W    = 4;
    localparam int COIN_GAP = 2;
    localparam int TIMEOUT  = 15;
    localparam int NO_STALL = 99;

    localparam int K_COIN = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        logic [1:0] coin;
        int         rem;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             busy, done, err;
    logic [AMT_W-1:0] remaining;

    coin_change_dispenser_if #(.AMT_W(AMT_W)) bus ();

    coin_change_dispenser #(
        .AMT_W   (AMT_W),
        .COIN_GAP(COIN_GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic pop_expect(input int kind, output ev_t e, output bit ok);
        checks++;
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual=kind%0d required=none at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            checks--;
            check("event_kind", kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    // ---------------- coin mechanism model ----------------
    int stall_at = NO_STALL;
    int ack_cnt  = 0;
    int ack_dly  = 0;
    int coin_idx = 0;

    initial begin
        bus.coin_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!busy) coin_idx = 0;
            if (bus.coin_valid) begin
                bus.coin_ack = (coin_idx != stall_at) && (ack_cnt == ack_dly);
                if (bus.coin_ack) coin_idx++;
                ack_cnt++;
            end else begin
                ack_cnt      = 0;
                // Occasionally ack on the very last edge before the timeout.
                ack_dly      = ($urandom_range(5) == 0) ? TIMEOUT - 1 : int'($urandom_range(2));
                bus.coin_ack = ($urandom_range(2) == 0);
            end
        end
    end

    // ---------------- monitor ----------------
    bit         mon_en   = 1'b0;
    bit         first    = 1'b1;
    int         low_cnt  = 0;
    int         hi_cnt   = 0;
    int         last_run = 0;
    logic [1:0] held     = 2'b00;

    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (mon_en && !rst) begin
            check("ready_is_not_busy", int'(bus.req_ready), int'(!busy));
            if (!busy) begin
                first   = 1'b1;
                low_cnt = 0;
                hi_cnt  = 0;
            end else if (!bus.coin_valid) begin
                check("coin_zero_when_invalid", int'(bus.coin), 0);
                if (hi_cnt > 0) last_run = hi_cnt;
                hi_cnt = 0;
                low_cnt++;
            end else begin
                if (hi_cnt == 0) begin
                    check("coin_spacing", low_cnt, first ? 1 : COIN_GAP + 1);
                    first   = 1'b0;
                    low_cnt = 0;
                    held    = bus.coin;
                end else begin
                    check("coin_stable", int'(bus.coin), int'(held));
                end
                hi_cnt++;
                if (bus.coin_ack) begin
                    pop_expect(K_COIN, e, ok);
                    if (ok) begin
                        check("coin_code", int'(bus.coin), int'(e.coin));
                        check("remaining_before_coin", int'(remaining), e.rem);
                    end
                end
            end
            if (done) begin
                pop_expect(K_DONE, e, ok);
                if (ok) begin
                    check("done_remaining", int'(remaining), 0);
                    check("done_err_low", int'(err), 0);
                end
            end
            if (err && busy) begin
                pop_expect(K_ERR, e, ok);
                if (ok) begin
                    check("err_unpaid", int'(remaining), e.rem);
                    check("timeout_length", last_run, TIMEOUT);
                end
            end
        end
    end

    // ---------------- reference model + stimulus ----------------
    function automatic int coin_count(input int a);
        return a / 5 + (a % 5) / 2 + (a % 5) % 2;
    endfunction

    task automatic do_request(input int amt, input int stall);
        int  rem, idx, v, wc;
        bit  stalled;
        ev_t e;
        wc = 0;
        while (!bus.req_ready && wc < 100) begin
            @(posedge clk); #1;
            wc++;
        end
        check("idle_before_request", int'(bus.req_ready), 1);

        stall_at = stall;
        rem      = amt;
        idx      = 0;
        stalled  = 1'b0;
        while (rem > 0 && !stalled) begin
            v = (rem >= 5) ? 5 : (rem >= 2) ? 2 : 1;
            if (idx == stall) begin
                e = '{kind: K_ERR, coin: 2'b00, rem: rem};
                exp_q.push_back(e);
                stalled = 1'b1;
            end else begin
                e = '{kind: K_COIN, coin: (v == 5) ? 2'b11 : (v == 2) ? 2'b10 : 2'b01, rem: rem};
                exp_q.push_back(e);
                rem -= v;
                idx++;
            end
        end
        if (!stalled) begin
            e = '{kind: K_DONE, coin: 2'b00, rem: 0};
            exp_q.push_back(e);
        end

        bus.req_valid = 1'b1;
        bus.req_amt   = AMT_W'(amt);
        @(posedge clk); #1;
        check("busy_after_accept", int'(busy), 1);
        check("err_cleared_on_accept", int'(err), 0);
        if (amt == 0) check("zero_amount_done", int'(done), 1);

        // Extra requests while busy must be ignored.
        wc = 0;
        while (busy && wc < 400) begin
            if (done || err) begin
                bus.req_valid = 1'b0;
            end else begin
                bus.req_valid = $urandom_range(1) == 1;
                bus.req_amt   = AMT_W'($urandom);
            end
            @(posedge clk); #1;
            wc++;
        end
        bus.req_valid = 1'b0;
        check("request_finished", int'(busy), 0);
        check("scoreboard_drained", exp_q.size(), 0);
        check("err_sticky_state", int'(err), int'(stalled));
        if (stalled) check("ready_after_err", int'(bus.req_ready), 1);
        exp_q.delete();
    endtask

    initial begin
        int amt, n, wc;
        bus.req_valid = 1'b0;
        bus.req_amt   = '0;

        #1 rst = 1'b1;
        #2;
        check("rst_req_ready",  int'(bus.req_ready),  1);
        check("rst_coin_valid", int'(bus.coin_valid), 0);
        check("rst_coin",       int'(bus.coin),       0);
        check("rst_busy",       int'(busy),           0);
        check("rst_done",       int'(done),           0);
        check("rst_err",        int'(err),            0);
        check("rst_remaining",  int'(remaining),      0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        do_request(8, NO_STALL);
        do_request(0, NO_STALL);
        do_request(4, NO_STALL);
        do_request(6, 0);
        do_request(5, NO_STALL);
        do_request(15, 2);
        do_request(1, NO_STALL);

        for (int i = 0; i < 40; i++) begin
            amt = int'($urandom_range(15));
            n   = coin_count(amt);
            if (amt > 0 && $urandom_range(4) == 0) do_request(amt, int'($urandom_range(n - 1)));
            else                                   do_request(amt, NO_STALL);
        end

        // Asynchronous reset in the middle of a coin presentation.
        mon_en   = 1'b0;
        stall_at = NO_STALL;
        bus.req_valid = 1'b1;
        bus.req_amt   = AMT_W'(7);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wc = 0;
        while (!bus.coin_valid && wc < 20) begin
            @(posedge clk); #1;
            wc++;
        end
        check("coin_before_reset", int'(bus.coin_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_coin_valid", int'(bus.coin_valid), 0);
        check("async_rst_coin",       int'(bus.coin),       0);
        check("async_rst_remaining",  int'(remaining),      0);
        check("async_rst_busy",       int'(busy),           0);
        check("async_rst_ready",      int'(bus.req_ready),  1);
        #2 rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        mon_en = 1'b1;

        do_request(7, NO_STALL);
        do_request(9, NO_STALL);
        do_request(3, 0);
        do_request(2, NO_STALL);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
